// File: rtl/graphics_processor.sv
// -----------------------------------------------------------------------------
// graphics_processor
//   Rectangle raster engine. A command (solid fill or background-ROM copy) is
//   accepted from the game controller over the gp_* handshake. The engine then
//   writes one 12-bit pixel per clock into the VRAM write port, scanning the
//   rectangle row by row, left to right.
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   gp_en        command request, held high by the master until gp_finish
//   gp_opcode    0 = solid fill with gp_arg, 1 = copy from background ROM
//   gp_tl_x/y    top-left corner (inclusive)
//   gp_br_x/y    bottom-right corner (inclusive, clamped to the screen)
//   gp_arg       fill colour {R,G,B}
//   gp_finish    command complete (done_r & gp_en)
//   vram_we      VRAM write strobe
//   vram_addr    VRAM write address (y*H_RES + x)
//   vram_data    VRAM write data
//   rom_addr     background ROM read address (ROM has 1-cycle read latency)
//   rom_data     background ROM read data
//
// Handshake: the master raises gp_en with a stable command and keeps it high.
// The command is captured on the first edge where gp_en=1 and done_r=0. When
// the rectangle is finished, done_r is set and gp_finish follows gp_en. The
// master then lowers gp_en, which drops gp_finish in the same cycle. On the
// next edge, done_r clears and the engine returns to IDLE, so gp_en may be
// raised again one cycle later.
// -----------------------------------------------------------------------------
module graphics_processor #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gp_en,
   input  logic              gp_opcode,
   input  logic [9:0]        gp_tl_x,
   input  logic [8:0]        gp_tl_y,
   input  logic [9:0]        gp_br_x,
   input  logic [8:0]        gp_br_y,
   input  logic [11:0]       gp_arg,
   output logic              gp_finish,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [11:0]       vram_data,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data
);

   localparam logic [9:0]        X_MAX    = 10'(H_RES - 1);
   localparam logic [8:0]        Y_MAX    = 9'(V_RES - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      COPY  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state;
   logic              done_r;
   logic              src_rom;   // vram_data comes from the ROM (copy) rather than arg_r
   logic [11:0]       arg_r;
   logic [9:0]        tl_x_r;
   logic [9:0]        bx_r;
   logic [8:0]        by_r;
   logic [9:0]        x_r;
   logic [8:0]        y_r;
   logic [ADDR_W-1:0] row_base;

   logic [9:0]        br_x_c;
   logic [8:0]        br_y_c;
   logic              empty;
   logic [ADDR_W-1:0] start_base;
   logic [ADDR_W-1:0] start_addr;
   logic              end_x;
   logic              last_px;
   logic [9:0]        nx;
   logic [8:0]        ny;
   logic [ADDR_W-1:0] nrow;
   logic [ADDR_W-1:0] next_addr;

   // Command decode at the start edge, plus next-pixel stepping of the scan.
   always_comb begin
      br_x_c     = (gp_br_x > X_MAX) ? X_MAX : gp_br_x;
      br_y_c     = (gp_br_y > Y_MAX) ? Y_MAX : gp_br_y;
      empty      = (gp_tl_x > br_x_c) || (gp_tl_y > br_y_c);
      start_base = ADDR_W'(gp_tl_y) * ROW_STEP;
      start_addr = start_base + ADDR_W'(gp_tl_x);

      end_x      = (x_r == bx_r);
      last_px    = end_x && (y_r == by_r);
      nx         = end_x ? tl_x_r : x_r + 10'd1;
      ny         = end_x ? y_r + 9'd1 : y_r;
      nrow       = end_x ? row_base + ROW_STEP : row_base;
      next_addr  = nrow + ADDR_W'(nx);
   end

   // The ROM data arrives exactly in the cycle its write is presented, so in
   // copy mode the data path bypasses the register.
   assign vram_data = src_rom ? rom_data : arg_r;
   assign gp_finish = done_r & gp_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         done_r    <= 1'b0;
         src_rom   <= 1'b0;
         arg_r     <= '0;
         tl_x_r    <= '0;
         bx_r      <= '0;
         by_r      <= '0;
         x_r       <= '0;
         y_r       <= '0;
         row_base  <= '0;
         vram_we   <= 1'b0;
         vram_addr <= '0;
         rom_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               vram_we <= 1'b0;
               if (gp_en && !done_r) begin
                  arg_r    <= gp_arg;
                  tl_x_r   <= gp_tl_x;
                  bx_r     <= br_x_c;
                  by_r     <= br_y_c;
                  x_r      <= gp_tl_x;
                  y_r      <= gp_tl_y;
                  row_base <= start_base;
                  src_rom  <= gp_opcode;
                  if (empty) begin
                     state  <= DONE;
                     done_r <= 1'b1;
                  end else if (!gp_opcode) begin
                     // First fill pixel is presented straight from the start edge.
                     state     <= FILL;
                     vram_we   <= 1'b1;
                     vram_addr <= start_addr;
                  end else begin
                     state    <= COPY;
                     rom_addr <= start_addr;
                  end
               end
            end

            FILL: begin
               if (last_px) begin
                  vram_we <= 1'b0;
                  state   <= DONE;
                  done_r  <= 1'b1;
               end else begin
                  x_r       <= nx;
                  y_r       <= ny;
                  row_base  <= nrow;
                  vram_we   <= 1'b1;
                  vram_addr <= next_addr;
               end
            end

            COPY: begin
               // Write the pixel whose ROM read was issued last cycle.
               vram_we   <= 1'b1;
               vram_addr <= rom_addr;
               if (last_px) begin
                  state <= DRAIN;
               end else begin
                  x_r      <= nx;
                  y_r      <= ny;
                  row_base <= nrow;
                  rom_addr <= next_addr;
               end
            end

            DRAIN: begin
               vram_we <= 1'b0;
               state   <= DONE;
               done_r  <= 1'b1;
            end

            DONE: begin
               vram_we <= 1'b0;
               if (!gp_en) begin
                  done_r <= 1'b0;
                  state  <= IDLE;
               end
            end

            default: begin
               vram_we <= 1'b0;
               done_r  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_graphics_processor.sv
// -----------------------------------------------------------------------------
// tb_graphics_processor
//   Drives rectangle commands into graphics_processor. The VRAM writes it
//   produces are collected in order. Each command's writes are compared with
//   a reference model that enumerates the clamped rectangle with nested loops.
//   The background ROM is a synchronous lookup of a fixed address hash.
// -----------------------------------------------------------------------------
module tb_graphics_processor;

   localparam int AW = 19;
   localparam int W  = AW + 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          gp_en = 1'b0;
   logic          gp_opcode = 1'b0;
   logic [9:0]    gp_tl_x = '0;
   logic [8:0]    gp_tl_y = '0;
   logic [9:0]    gp_br_x = '0;
   logic [8:0]    gp_br_y = '0;
   logic [11:0]   gp_arg = '0;
   logic          gp_finish;
   logic          vram_we;
   logic [AW-1:0] vram_addr;
   logic [11:0]   vram_data;
   logic [AW-1:0] rom_addr;
   logic [11:0]   rom_data = '0;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  got_q[$];
   int            got_cyc[$];
   logic [AW-1:0] rom_hist[0:1023];

   graphics_processor dut (
      .clk       (clk),
      .rst       (rst),
      .gp_en     (gp_en),
      .gp_opcode (gp_opcode),
      .gp_tl_x   (gp_tl_x),
      .gp_tl_y   (gp_tl_y),
      .gp_br_x   (gp_br_x),
      .gp_br_y   (gp_br_y),
      .gp_arg    (gp_arg),
      .gp_finish (gp_finish),
      .vram_we   (vram_we),
      .vram_addr (vram_addr),
      .vram_data (vram_data),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- background ROM model ----------------
   function automatic logic [11:0] rom_fn(input logic [AW-1:0] a);
      if (a == 19'd0) return 12'h111;
      if (a == 19'd1) return 12'h222;
      return a[11:0] ^ {a[18:13], a[5:0]} ^ 12'h5A5;
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   // ---------------- write monitor ----------------
   always @(negedge clk) begin
      rom_hist[cyc % 1024] = rom_addr;
      if (!rst && vram_we) begin
         got_q.push_back({vram_addr, vram_data});
         got_cyc.push_back(cyc);
      end
   end

   // ---------------- reference model ----------------
   function automatic void build_exp(input bit op, input int tlx, input int tly,
                                     input int brx, input int bry, input logic [11:0] arg);
      int bx, by, a;
      exp_q.delete();
      bx = (brx > 639) ? 639 : brx;
      by = (bry > 479) ? 479 : bry;
      for (int y = tly; y <= by; y++)
         for (int x = tlx; x <= bx; x++) begin
            a = y * 640 + x;
            exp_q.push_back({AW'(a), op ? rom_fn(AW'(a)) : arg});
         end
   endfunction

   function automatic int count_diffs();
      int n, d;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      d = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                        : exp_q.size() - got_q.size();
      for (int k = 0; k < n; k++) if (got_q[k] !== exp_q[k]) d++;
      return d;
   endfunction

   // Fill writes start the cycle after the start edge, copy writes one cycle
   // later; writes are gapless and finish is seen the cycle after the last.
   function automatic int timing_errors(input bit op, input int start_cyc, input int fin_cyc);
      int errs, n, first;
      errs  = 0;
      n     = exp_q.size();
      first = start_cyc + 1 + int'(op);
      if (fin_cyc < 0) return 1;
      if (n == 0) return (fin_cyc != start_cyc + 1) ? 1 : 0;
      if (got_cyc.size() != n) errs++;
      else for (int k = 0; k < n; k++) if (got_cyc[k] != first + k) errs++;
      if (fin_cyc != first + n) errs++;
      return errs;
   endfunction

   // ---------------- driver ----------------
   // Called just after a falling edge; the command starts on the next rising edge.
   task automatic do_cmd(input bit op, input int tlx, input int tly, input int brx,
                         input int bry, input logic [11:0] arg, output int start_cyc,
                         output int fin_cyc, output logic fin_drop, output logic fin_gap);
      got_q.delete();
      got_cyc.delete();
      gp_opcode = op;
      gp_tl_x   = 10'(tlx);
      gp_tl_y   = 9'(tly);
      gp_br_x   = 10'(brx);
      gp_br_y   = 9'(bry);
      gp_arg    = arg;
      gp_en     = 1'b1;
      start_cyc = cyc;
      fin_cyc   = -1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk); #1;
         if (i == 0) begin
            // Command inputs are captured at the start edge only.
            gp_opcode = 1'($urandom);
            gp_tl_x   = 10'($urandom);
            gp_tl_y   = 9'($urandom);
            gp_br_x   = 10'($urandom);
            gp_br_y   = 9'($urandom);
            gp_arg    = 12'($urandom);
         end
         if (gp_finish) begin
            fin_cyc = cyc;
            break;
         end
      end
      gp_en = 1'b0;
      #1 fin_drop = gp_finish;
      @(negedge clk); #1 fin_gap = gp_finish;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      gp_en = 1'b1; gp_opcode = 1'b0; gp_tl_x = 10'd1; gp_br_x = 10'd5;
      gp_tl_y = 9'd1; gp_br_y = 9'd5; gp_arg = 12'h123;
      repeat (3) @(negedge clk);
      #1;
      tests++; if (vram_we !== 1'b0) begin failed++; $display("FAIL reset_we got %b want 0", vram_we); end
      tests++; if (vram_addr !== '0) begin failed++; $display("FAIL reset_vram_addr got %0d want 0", vram_addr); end
      tests++; if (vram_data !== '0) begin failed++; $display("FAIL reset_vram_data got %h want 000", vram_data); end
      tests++; if (rom_addr !== '0) begin failed++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
      tests++; if (gp_finish !== 1'b0) begin failed++; $display("FAIL reset_finish got %b want 0", gp_finish); end
      gp_en = 1'b0;
      rst   = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_fill_small();
      int s, f; logic fd, fg;
      build_exp(1'b0, 10, 20, 11, 21, 12'hABC);
      do_cmd(1'b0, 10, 20, 11, 21, 12'hABC, s, f, fd, fg);
      tests++; if (got_q.size() != 4) begin failed++; $display("FAIL fill_small_count got %0d want 4", got_q.size()); end
      tests++; if (count_diffs() != 0) begin failed++; $display("FAIL fill_small_data got %0d mismatches want 0", count_diffs()); end
      if (got_q.size() == 4) begin
         tests++; if (got_q[0] !== {19'd12810, 12'hABC}) begin failed++; $display("FAIL fill_small_first got %h want %h", got_q[0], {19'd12810, 12'hABC}); end
         tests++; if (got_q[3] !== {19'd13451, 12'hABC}) begin failed++; $display("FAIL fill_small_last got %h want %h", got_q[3], {19'd13451, 12'hABC}); end
      end
      tests++; if (timing_errors(1'b0, s, f) != 0) begin failed++; $display("FAIL fill_small_timing got %0d errors (fin=%0d start=%0d) want 0", timing_errors(1'b0, s, f), f, s); end
   endtask

   task automatic test_copy_small();
      int s, f; logic fd, fg;
      build_exp(1'b1, 0, 0, 1, 0, 12'h000);
      do_cmd(1'b1, 0, 0, 1, 0, 12'hFFF, s, f, fd, fg);
      tests++; if (count_diffs() != 0) begin failed++; $display("FAIL copy_small_data got %0d mismatches want 0", count_diffs()); end
      if (got_q.size() == 2) begin
         tests++; if (got_q[1] !== {19'd1, 12'h222}) begin failed++; $display("FAIL copy_small_second got %h want %h", got_q[1], {19'd1, 12'h222}); end
         tests++; if (rom_hist[(got_cyc[0] - 1) % 1024] !== 19'd0) begin failed++; $display("FAIL copy_rom_addr0 got %0d want 0", rom_hist[(got_cyc[0] - 1) % 1024]); end
         tests++; if (rom_hist[(got_cyc[1] - 1) % 1024] !== 19'd1) begin failed++; $display("FAIL copy_rom_addr1 got %0d want 1", rom_hist[(got_cyc[1] - 1) % 1024]); end
      end else begin
         tests++; failed++; $display("FAIL copy_small_count got %0d want 2", got_q.size());
      end
      tests++; if (timing_errors(1'b1, s, f) != 0) begin failed++; $display("FAIL copy_small_timing got %0d errors want 0", timing_errors(1'b1, s, f)); end
   endtask

   task automatic test_clamp();
      int s, f; logic fd, fg;
      build_exp(1'b0, 630, 0, 700, 0, 12'h0F0);
      do_cmd(1'b0, 630, 0, 700, 0, 12'h0F0, s, f, fd, fg);
      tests++; if (got_q.size() != 10) begin failed++; $display("FAIL clamp_count got %0d want 10", got_q.size()); end
      tests++; if (count_diffs() != 0) begin failed++; $display("FAIL clamp_data got %0d mismatches want 0", count_diffs()); end
      tests++; if (timing_errors(1'b0, s, f) != 0) begin failed++; $display("FAIL clamp_timing got %0d errors want 0", timing_errors(1'b0, s, f)); end
   endtask

   task automatic test_empty();
      int s, f; logic fd, fg;
      do_cmd(1'b0, 5, 5, 4, 5, 12'h777, s, f, fd, fg);
      tests++; if (got_q.size() != 0) begin failed++; $display("FAIL empty_count got %0d want 0", got_q.size()); end
      tests++; if (f < 0 || f - s > 2) begin failed++; $display("FAIL empty_finish_latency got %0d want <=2", f - s); end
   endtask

   task automatic test_corner();
      int s, f; logic fd, fg;
      build_exp(1'b1, 600, 440, 1023, 511, 12'h000);
      do_cmd(1'b1, 600, 440, 1023, 511, 12'h000, s, f, fd, fg);
      tests++; if (got_q.size() != 1600) begin failed++; $display("FAIL corner_count got %0d want 1600", got_q.size()); end
      tests++; if (count_diffs() != 0) begin failed++; $display("FAIL corner_data got %0d mismatches want 0", count_diffs()); end
      if (got_q.size() > 0) begin
         tests++; if (got_q[got_q.size() - 1][W-1:12] !== 19'd307199) begin failed++; $display("FAIL corner_last_addr got %0d want 307199", got_q[got_q.size() - 1][W-1:12]); end
      end
      tests++; if (timing_errors(1'b1, s, f) != 0) begin failed++; $display("FAIL corner_timing got %0d errors want 0", timing_errors(1'b1, s, f)); end
   endtask

   task automatic test_back_to_back();
      int s, f; logic fd, fg;
      build_exp(1'b0, 20, 30, 22, 31, 12'h3C3);
      do_cmd(1'b0, 20, 30, 22, 31, 12'h3C3, s, f, fd, fg);
      tests++; if (fd !== 1'b0) begin failed++; $display("FAIL b2b_finish_drop got %b want 0", fd); end
      tests++; if (fg !== 1'b0) begin failed++; $display("FAIL b2b_finish_gap got %b want 0", fg); end
      build_exp(1'b1, 300, 200, 303, 201, 12'h000);
      do_cmd(1'b1, 300, 200, 303, 201, 12'h999, s, f, fd, fg);
      tests++; if (count_diffs() != 0) begin failed++; $display("FAIL b2b_second_data got %0d mismatches want 0", count_diffs()); end
      tests++; if (timing_errors(1'b1, s, f) != 0) begin failed++; $display("FAIL b2b_second_timing got %0d errors want 0", timing_errors(1'b1, s, f)); end
   endtask

   task automatic test_reset_mid();
      int s, f;
      build_exp(1'b0, 100, 50, 103, 53, 12'h5E5);
      got_q.delete(); got_cyc.delete();
      gp_opcode = 1'b0; gp_tl_x = 10'd100; gp_tl_y = 9'd50;
      gp_br_x = 10'd103; gp_br_y = 9'd53; gp_arg = 12'h5E5; gp_en = 1'b1;
      repeat (3) begin @(negedge clk); #1; end
      rst = 1'b1;
      @(negedge clk); #1;
      tests++; if (vram_we !== 1'b0) begin failed++; $display("FAIL reset_mid_we got %b want 0", vram_we); end
      tests++; if (got_q.size() != 3) begin failed++; $display("FAIL reset_mid_partial got %0d want 3", got_q.size()); end
      rst = 1'b0;
      got_q.delete(); got_cyc.delete();
      s = cyc; f = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (gp_finish) begin f = cyc; break; end
      end
      tests++; if (count_diffs() != 0) begin failed++; $display("FAIL reset_mid_restart got %0d mismatches want 0", count_diffs()); end
      tests++; if (timing_errors(1'b0, s, f) != 0) begin failed++; $display("FAIL reset_mid_timing got %0d errors want 0", timing_errors(1'b0, s, f)); end
      gp_en = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_random();
      int s, f, tlx, tly, brx, bry; bit op; logic [11:0] arg; logic fd, fg;
      for (int it = 0; it < 25; it++) begin
         op  = 1'($urandom);
         arg = 12'($urandom);
         tlx = $urandom_range(0, 639);
         tly = $urandom_range(0, 479);
         brx = tlx + $urandom_range(0, 15);
         bry = tly + $urandom_range(0, 6);
         if ($urandom_range(0, 5) == 0 && tlx > 0) brx = tlx - 1;
         if ($urandom_range(0, 5) == 0 && tly > 0) bry = tly - 1;
         build_exp(op, tlx, tly, brx, bry, arg);
         do_cmd(op, tlx, tly, brx, bry, arg, s, f, fd, fg);
         tests++; if (count_diffs() != 0) begin failed++; $display("FAIL random_%0d_data got %0d mismatches want 0 (op=%0d %0d,%0d-%0d,%0d)", it, count_diffs(), op, tlx, tly, brx, bry); end
         tests++; if (timing_errors(op, s, f) != 0) begin failed++; $display("FAIL random_%0d_timing got %0d errors want 0", it, timing_errors(op, s, f)); end
         tests++; if (fd !== 1'b0) begin failed++; $display("FAIL random_%0d_finish_drop got %b want 0", it, fd); end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_fill_small();
      test_copy_small();
      test_clamp();
      test_empty();
      test_corner();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
